// File: rtl/histogram_lut_builder_if.sv
// Histogram BRAM read port and LUT BRAM write port
// seen from the LUT builder (master) and the memories (slave).
interface histogram_lut_builder_if #(
    parameter int WD_BRAM_ADR = 8,
    parameter int WD_BRAM_DAT = 32,
    parameter int WD_IMG_DATA = 8
);
    logic                   m_bram_hist_enb;
    logic [WD_BRAM_ADR-1:0] m_bram_hist_addrb;
    logic [WD_BRAM_DAT-1:0] m_bram_hist_doutb;
    logic                   m_bram_lut_ena;
    logic                   m_bram_lut_wea;
    logic [WD_BRAM_ADR-1:0] m_bram_lut_addra;
    logic [WD_IMG_DATA-1:0] m_bram_lut_dina;

    modport master (
        output m_bram_hist_enb,
        output m_bram_hist_addrb,
        input  m_bram_hist_doutb,
        output m_bram_lut_ena,
        output m_bram_lut_wea,
        output m_bram_lut_addra,
        output m_bram_lut_dina
    );

    modport slave (
        input  m_bram_hist_enb,
        input  m_bram_hist_addrb,
        output m_bram_hist_doutb,
        input  m_bram_lut_ena,
        input  m_bram_lut_wea,
        input  m_bram_lut_addra,
        input  m_bram_lut_dina
    );
endinterface

// File: rtl/histogram_lut_builder.sv
// Builds a histogram-equalization LUT at each frame end:
// sweeps the histogram, accumulates the CDF, scales it to output levels.
module histogram_lut_builder #(
    parameter int NB_BRAM_DLY = 2,
    parameter int NB_IMG_HORI = 960,
    parameter int NB_IMG_VERT = 640,
    parameter int WD_IMG_DATA = 8,
    parameter int WD_BRAM_ADR = 8,
    parameter int WD_BRAM_DAT = 32,
    parameter int WD_FRAC     = 24,
    parameter int WD_ERR_INFO = 4
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_reset,
    input  logic                   s_img_gray_c_fsync,
    histogram_lut_builder_if.master bram,
    output logic                   m_lut_busy,
    output logic                   m_lut_done,
    output logic [WD_ERR_INFO-1:0] m_err_lut_info1
);
    localparam int NB_IMG_DATA = 2 ** WD_IMG_DATA;
    localparam int TOTAL       = NB_IMG_HORI * NB_IMG_VERT;
    localparam int WD_IMG_MAXS = $clog2(TOTAL + 1);
    localparam int WD_CDF      = WD_IMG_MAXS + WD_IMG_DATA;
    localparam int WD_K        = WD_IMG_DATA + WD_FRAC;
    localparam int WD_PRD      = WD_CDF + WD_K;
    localparam int WD_LVL      = WD_PRD - WD_FRAC;

    localparam longint unsigned K_FULL =
        (longint'(NB_IMG_DATA - 1) << WD_FRAC) / longint'(TOTAL);
    localparam logic [WD_K-1:0]        K     = WD_K'(K_FULL);
    localparam logic [WD_PRD-1:0]      HALF  = WD_PRD'(1) << (WD_FRAC - 1);
    localparam logic [WD_BRAM_ADR-1:0] LAST  = WD_BRAM_ADR'(NB_IMG_DATA - 1);
    localparam logic [WD_CDF-1:0]      CSUM  = WD_CDF'(TOTAL);
    localparam logic [WD_LVL-1:0]      LVMAX = WD_LVL'(NB_IMG_DATA - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state;
    logic   fs_q;
    logic   fall;
    logic   start;
    logic   err_busy;
    logic   err_sum;
    logic   err_sat;

    logic [NB_BRAM_DLY-1:0] sh_vld;
    logic [WD_BRAM_ADR-1:0] sh_adr [NB_BRAM_DLY];
    logic [WD_CDF-1:0]      cdf;
    logic                   s1_vld;
    logic [WD_BRAM_ADR-1:0] s1_adr;
    logic [WD_PRD-1:0]      prod;
    logic                   s2_vld;
    logic [WD_BRAM_ADR-1:0] s2_adr;
    logic [WD_LVL-1:0]      lvl;
    logic                   sat;
    logic                   unused_bits;

    assign fall  = fs_q & ~s_img_gray_c_fsync;
    assign start = fall && (state == IDLE);
    assign lvl   = prod[WD_PRD-1:WD_FRAC];
    assign sat   = lvl > LVMAX;

    assign m_lut_busy  = (state != IDLE);
    assign unused_bits = ^bram.m_bram_hist_doutb[WD_BRAM_DAT-1:WD_IMG_MAXS];

    always_comb begin
        m_err_lut_info1    = '0;
        m_err_lut_info1[0] = err_busy;
        m_err_lut_info1[1] = err_sum;
        m_err_lut_info1[2] = err_sat;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state                  <= IDLE;
            fs_q                   <= 1'b0;
            bram.m_bram_hist_enb   <= 1'b0;
            bram.m_bram_hist_addrb <= '0;
            m_lut_done             <= 1'b0;
            err_busy               <= 1'b0;
            err_sum                <= 1'b0;
        end else begin
            fs_q       <= s_img_gray_c_fsync;
            m_lut_done <= 1'b0;
            // a request arriving mid-build is dropped, only flagged
            if (fall && state != IDLE) err_busy <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        state                  <= READ;
                        bram.m_bram_hist_enb   <= 1'b1;
                        bram.m_bram_hist_addrb <= '0;
                    end
                end
                READ: begin
                    if (bram.m_bram_hist_addrb == LAST) begin
                        state                  <= DRAIN;
                        bram.m_bram_hist_enb   <= 1'b0;
                        bram.m_bram_hist_addrb <= '0;
                    end else begin
                        bram.m_bram_hist_addrb <=
                            bram.m_bram_hist_addrb + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bram.m_bram_lut_ena &&
                        bram.m_bram_lut_addra == LAST) begin
                        state      <= DONE;
                        m_lut_done <= 1'b1;
                        if (cdf != CSUM) err_sum <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            sh_vld                <= '0;
            for (int i = 0; i < NB_BRAM_DLY; i++) sh_adr[i] <= '0;
            cdf                   <= '0;
            s1_vld                <= 1'b0;
            s1_adr                <= '0;
            prod                  <= '0;
            s2_vld                <= 1'b0;
            s2_adr                <= '0;
            bram.m_bram_lut_ena   <= 1'b0;
            bram.m_bram_lut_wea   <= 1'b0;
            bram.m_bram_lut_addra <= '0;
            bram.m_bram_lut_dina  <= '0;
            err_sat               <= 1'b0;
        end else begin
            // tag each read with its bin until the BRAM data returns
            sh_vld[0] <= bram.m_bram_hist_enb;
            sh_adr[0] <= bram.m_bram_hist_addrb;
            for (int i = 1; i < NB_BRAM_DLY; i++) begin
                sh_vld[i] <= sh_vld[i-1];
                sh_adr[i] <= sh_adr[i-1];
            end

            s1_vld <= sh_vld[NB_BRAM_DLY-1];
            s1_adr <= sh_adr[NB_BRAM_DLY-1];
            if (start) begin
                cdf <= '0;
            end else if (sh_vld[NB_BRAM_DLY-1]) begin
                cdf <= cdf + WD_CDF'(
                    bram.m_bram_hist_doutb[WD_IMG_MAXS-1:0]);
            end

            s2_vld <= s1_vld;
            s2_adr <= s1_adr;
            prod   <= WD_PRD'(cdf) * WD_PRD'(K) + HALF;

            bram.m_bram_lut_ena   <= s2_vld;
            bram.m_bram_lut_wea   <= s2_vld;
            bram.m_bram_lut_addra <= s2_adr;
            if (s2_vld) begin
                bram.m_bram_lut_dina <= sat ? LVMAX[WD_IMG_DATA-1:0]
                                            : lvl[WD_IMG_DATA-1:0];
                if (sat) err_sat <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_histogram_lut_builder.sv
// Randomized bench for histogram_lut_builder with a behavioural
// equalization model and a latency-accurate histogram BRAM model.
module tb_histogram_lut_builder;
    localparam int D     = 2;
    localparam int HORI  = 960;
    localparam int VERT  = 640;
    localparam int WD    = 8;
    localparam int WA    = 8;
    localparam int WDAT  = 32;
    localparam int WF    = 24;
    localparam int WE    = 4;
    localparam int TOTAL = HORI * VERT;
    localparam int NBIN  = 2 ** WD;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          fsync = 1'b0;
    logic          busy;
    logic          done;
    logic [WE-1:0] err;

    int checks = 0;
    int errors = 0;

    logic [WDAT-1:0] mem [NBIN];
    logic [WDAT-1:0] rdp [D];
    int              exp_lut [NBIN];
    int              lut_obs [NBIN];
    logic [3:0]      exp_err;

    histogram_lut_builder_if #(
        .WD_BRAM_ADR(WA), .WD_BRAM_DAT(WDAT), .WD_IMG_DATA(WD)
    ) bram ();

    histogram_lut_builder #(
        .NB_BRAM_DLY(D), .NB_IMG_HORI(HORI), .NB_IMG_VERT(VERT),
        .WD_IMG_DATA(WD), .WD_BRAM_ADR(WA), .WD_BRAM_DAT(WDAT),
        .WD_FRAC(WF), .WD_ERR_INFO(WE)
    ) dut (
        .i_sys_clk         (clk),
        .i_sys_reset       (rst),
        .s_img_gray_c_fsync(fsync),
        .bram              (bram.master),
        .m_lut_busy        (busy),
        .m_lut_done        (done),
        .m_err_lut_info1   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdp[0] <= bram.m_bram_hist_enb ? mem[bram.m_bram_hist_addrb]
                                       : 32'hDEAD_BEEF;
        for (int i = 1; i < D; i++) rdp[i] <= rdp[i-1];
    end
    assign bram.m_bram_hist_doutb = rdp[D-1];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Equalization from first principles: running sum of the usable
    // count bits, scaled by the truncated constant, rounded half up.
    task automatic ref_model();
        longint k, c, lvl;
        int     maxs;
        logic   sat;
        maxs = 0;
        while ((longint'(1) << maxs) <= longint'(TOTAL)) maxs++;
        k   = (longint'(NBIN - 1) << WF) / longint'(TOTAL);
        c   = 0;
        sat = 1'b0;
        for (int b = 0; b < NBIN; b++) begin
            c   += longint'(mem[b]) % (longint'(1) << maxs);
            lvl  = (c * k + (longint'(1) << (WF - 1))) >> WF;
            if (lvl > NBIN - 1) begin
                lvl = NBIN - 1;
                sat = 1'b1;
            end
            exp_lut[b] = int'(lvl);
        end
        exp_err = {1'b0, sat, c != longint'(TOTAL), 1'b0};
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        fsync = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_const(input logic [WDAT-1:0] v);
        for (int b = 0; b < NBIN; b++) mem[b] = v;
    endtask

    task automatic fill_rand_norm(input logic junk);
        int rem, x, cap;
        rem = TOTAL;
        for (int b = 0; b < NBIN - 1; b++) begin
            cap    = (rem < 4800) ? rem : 4800;
            x      = $urandom_range(cap, 0);
            mem[b] = x;
            rem   -= x;
        end
        mem[NBIN-1] = rem;
        if (junk)
            for (int b = 0; b < NBIN; b++)
                mem[b] = mem[b] | ($urandom() & 32'hFFF0_0000);
    endtask

    task automatic build(input string nm, input int inj,
                         input logic [3:0] err_extra);
        int t_a0, t_w0, t_wl, t_done, nwr, ndone, bad;
        t_a0 = -1; t_w0 = -1; t_wl = -1; t_done = -1;
        nwr = 0; ndone = 0; bad = 0;
        ref_model();
        @(negedge clk) fsync = 1'b1;
        @(negedge clk);
        @(negedge clk) fsync = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (inj > 0 && n == inj) fsync = 1'b1;
            if (inj > 0 && n == inj + 2) fsync = 1'b0;
            if (bram.m_bram_hist_enb && bram.m_bram_hist_addrb == 0 &&
                t_a0 < 0) t_a0 = n;
            if ((bram.m_bram_hist_enb || bram.m_bram_lut_ena) && !busy)
                bad++;
            if (bram.m_bram_lut_ena) begin
                if (!bram.m_bram_lut_wea ||
                    int'(bram.m_bram_lut_addra) != nwr) bad++;
                lut_obs[bram.m_bram_lut_addra] = int'(bram.m_bram_lut_dina);
                if (nwr == 0) t_w0 = n;
                t_wl = n;
                nwr++;
            end
            if (done) begin
                ndone++;
                if (t_done < 0) t_done = n;
            end
            if (t_done >= 0 && n >= t_done + 4) break;
        end
        chk({nm, "_done_seen"}, t_done >= 0, 1);
        chk({nm, "_latency"}, t_w0 - t_a0, D + 3);
        chk({nm, "_nwrites"}, nwr, NBIN);
        chk({nm, "_span"}, t_wl - t_w0, NBIN - 1);
        chk({nm, "_done_dly"}, t_done - t_wl, 1);
        chk({nm, "_ndone"}, ndone, 1);
        chk({nm, "_protocol"}, bad, 0);
        for (int b = 0; b < NBIN; b++)
            chk({nm, "_lut"}, lut_obs[b], exp_lut[b]);
        chk({nm, "_err"}, err, exp_err | err_extra);
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        int found, nw, nb;
        do_reset();
        chk("rst_outs",
            {busy, done, err, bram.m_bram_hist_enb, bram.m_bram_lut_ena,
             bram.m_bram_lut_wea, bram.m_bram_hist_addrb,
             bram.m_bram_lut_addra, bram.m_bram_lut_dina}, 0);

        fill_const(2400);
        build("uniform", 0, 4'b0000);
        chk("uni_lut0", lut_obs[0], 1);
        chk("uni_lut255", lut_obs[NBIN-1], NBIN - 1);

        do_reset();
        fill_const(0);
        mem[100] = TOTAL;
        build("spike", 0, 4'b0000);
        chk("spike_lut99", lut_obs[99], 0);
        chk("spike_lut100", lut_obs[100], NBIN - 1);

        do_reset();
        fill_const(0);
        mem[0] = 1000;
        build("short", 0, 4'b0000);
        chk("short_err1", err[1], 1);

        do_reset();
        fill_const(2400);
        mem[5] = (1 << 20) - 1;
        build("sat", 0, 4'b0000);
        chk("sat_err2", err[2], 1);
        chk("sat_lut5", lut_obs[5], NBIN - 1);

        do_reset();
        fill_const(2400);
        build("inject", 50, 4'b0001);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            fill_rand_norm(r[0]);
            build("rnorm", 0, 4'b0000);
        end

        do_reset();
        for (int b = 0; b < NBIN; b++) mem[b] = $urandom_range(5000, 0);
        build("rraw", 0, 4'b0000);

        do_reset();
        fill_const(2400);
        @(negedge clk) fsync = 1'b1;
        @(negedge clk);
        @(negedge clk) fsync = 1'b0;
        found = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bram.m_bram_hist_enb && bram.m_bram_hist_addrb == 120) begin
                found = 1;
                break;
            end
        end
        chk("rmid_reach", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_outs",
            {busy, done, err, bram.m_bram_hist_enb, bram.m_bram_lut_ena,
             bram.m_bram_lut_wea, bram.m_bram_hist_addrb,
             bram.m_bram_lut_addra, bram.m_bram_lut_dina}, 0);
        rst = 1'b0;
        nw = 0;
        nb = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bram.m_bram_lut_ena) nw++;
            if (busy || done) nb++;
        end
        chk("rmid_nowrite", nw, 0);
        chk("rmid_quiet", nb, 0);
        fill_rand_norm(1'b0);
        build("after_rst", 0, 4'b0000);

        do_reset();
        @(negedge clk) fsync = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        fsync = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        nb  = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (busy || bram.m_bram_hist_enb) nb++;
        end
        chk("coinc_nobuild", nb, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
